// File: rtl/race_ctrl.sv
// race_ctrl: drag-race sequencing controller (idle, countdown, race, finish).
// Owns gear selection, throttle gating and false-start detection.
// Optional feature macro: RACE_CTRL_SHIFT_LOCKOUT_EN. When it is defined, each
// accepted shift blocks further shifts for LOCKOUT_CYCLES cycles.
module race_ctrl #(
  parameter int WIDTH          = 4,
  parameter int TICK_CYCLES    = 32_500_000,
  parameter int COUNT_STEPS    = 3,
  parameter int MAX_GEAR       = 5,
  parameter int LOCKOUT_CYCLES = 6_500_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] kb_key_pressed,
  input  logic             finish_line,
  output logic [1:0]       state,
  output logic [1:0]       countdown,
  output logic             go,
  output logic             throttle,
  output logic [2:0]       gear,
  output logic             shift_pulse,
  output logic             false_start
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_COUNTDOWN = 2'd1,
    S_RACE      = 2'd2,
    S_FINISH    = 2'd3
  } state_t;

  localparam int              TICK_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [1:0]      STEPS     = 2'(COUNT_STEPS);
  localparam logic [2:0]      GEAR_MAX  = 3'(MAX_GEAR);

  state_t              state_q, state_d;
  logic [1:0]          countdown_q, countdown_d;
  logic                go_q, go_d;
  logic                throttle_q, throttle_d;
  logic [2:0]          gear_q, gear_d;
  logic                shift_pulse_q, shift_pulse_d;
  logic                false_start_q, false_start_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [2:0]          prev_q, prev_d;   // previous {A,S,D}

  logic key_w, rise_a, rise_s, rise_d;
  logic locked;
  logic up_ok, down_ok;

  assign key_w  = kb_key_pressed[3];
  assign rise_a = kb_key_pressed[2] & ~prev_q[2];
  assign rise_s = kb_key_pressed[1] & ~prev_q[1];
  assign rise_d = kb_key_pressed[0] & ~prev_q[0];
  assign prev_d = kb_key_pressed[2:0];

  // A shift qualifies only on a lone edge, inside the gear range, outside lockout.
  assign up_ok   = rise_d & ~rise_s & (gear_q < GEAR_MAX) & ~locked;
  assign down_ok = rise_s & ~rise_d & (gear_q > 3'd1) & ~locked;

`ifdef RACE_CTRL_SHIFT_LOCKOUT_EN
  localparam int                LOCK_W    = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES - 1);

  logic [LOCK_W-1:0] lock_q, lock_d;

  assign locked = (lock_q != '0);

  // Lockout counter: reload on an accepted shift, count down, clear outside RACE.
  always_comb begin
    lock_d = lock_q;
    if (state_d != S_RACE) begin
      lock_d = '0;
    end else if (shift_pulse_d) begin
      lock_d = LOCK_LOAD;
    end else if (lock_q != '0) begin
      lock_d = lock_q - LOCK_W'(1);
    end
  end

  // Lockout counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lock_q <= '0;
    else       lock_q <= lock_d;
  end
`else
  assign locked = 1'b0;
`endif

  // Next-state and output logic for the race sequence.
  always_comb begin
    state_d       = state_q;
    countdown_d   = countdown_q;
    tick_d        = tick_q;
    gear_d        = gear_q;
    false_start_d = false_start_q;
    go_d          = 1'b0;
    shift_pulse_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rise_a) begin
          state_d       = S_COUNTDOWN;
          countdown_d   = STEPS;
          tick_d        = '0;
          gear_d        = 3'd1;
          false_start_d = 1'b0;
        end
      end
      S_COUNTDOWN: begin
        // Throttle during the lights beats any same-cycle light change.
        if (key_w) begin
          false_start_d = 1'b1;
          countdown_d   = 2'd0;
          tick_d        = '0;
          state_d       = S_FINISH;
        end else if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (countdown_q > 2'd1) begin
            countdown_d = countdown_q - 2'd1;
          end else begin
            countdown_d = 2'd0;
            go_d        = 1'b1;
            state_d     = S_RACE;
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      S_RACE: begin
        if (up_ok) begin
          gear_d        = gear_q + 3'd1;
          shift_pulse_d = 1'b1;
        end else if (down_ok) begin
          gear_d        = gear_q - 3'd1;
          shift_pulse_d = 1'b1;
        end
        if (finish_line) state_d = S_FINISH;
      end
      default: begin  // S_FINISH
        if (rise_a) begin
          state_d       = S_IDLE;
          false_start_d = 1'b0;
          gear_d        = 3'd1;
        end
      end
    endcase

    // Throttle follows W only while the car is (still) racing.
    throttle_d = (state_d == S_RACE) & key_w;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      countdown_q   <= 2'd0;
      go_q          <= 1'b0;
      throttle_q    <= 1'b0;
      gear_q        <= 3'd1;
      shift_pulse_q <= 1'b0;
      false_start_q <= 1'b0;
      tick_q        <= '0;
      prev_q        <= 3'd0;
    end else begin
      state_q       <= state_d;
      countdown_q   <= countdown_d;
      go_q          <= go_d;
      throttle_q    <= throttle_d;
      gear_q        <= gear_d;
      shift_pulse_q <= shift_pulse_d;
      false_start_q <= false_start_d;
      tick_q        <= tick_d;
      prev_q        <= prev_d;
    end
  end

  assign state       = state_q;
  assign countdown   = countdown_q;
  assign go          = go_q;
  assign throttle    = throttle_q;
  assign gear        = gear_q;
  assign shift_pulse = shift_pulse_q;
  assign false_start = false_start_q;

endmodule

// File: tb/tb_race_ctrl.sv
// tb_race_ctrl: directed stimulus for race_ctrl, checked every cycle against a
// cycle-count/integer model of the race rules plus literal expectations.
module tb_race_ctrl;
  localparam int TICK = 4;
  localparam int STEPS = 3;
  localparam int MAXG = 5;
  localparam int LOCK = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] kb = 4'd0;
  logic       fl = 1'b0;
  logic [1:0] state, countdown;
  logic       go, throttle, shift_pulse, false_start;
  logic [2:0] gear;

  int errors = 0;
  int checks = 0;
  bit started = 0;

  race_ctrl #(
    .WIDTH(4), .TICK_CYCLES(TICK), .COUNT_STEPS(STEPS),
    .MAX_GEAR(MAXG), .LOCKOUT_CYCLES(LOCK)
  ) dut (
    .clk(clk), .reset(reset), .kb_key_pressed(kb), .finish_line(fl),
    .state(state), .countdown(countdown), .go(go), .throttle(throttle),
    .gear(gear), .shift_pulse(shift_pulse), .false_start(false_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 countdown, 2 race, 3 finish; countdown light derived
  // from the number of cycles spent in the countdown.
  int m_phase = 0, m_elapsed = 0, m_gear = 1, m_lock = 0;
  bit m_go = 0, m_thr = 0, m_sp = 0, m_fs = 0;
  bit m_pa = 0, m_ps = 0, m_pd = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_elapsed = 0; m_gear = 1; m_lock = 0;
      m_go = 0; m_thr = 0; m_sp = 0; m_fs = 0;
      m_pa = 0; m_ps = 0; m_pd = 0;
    end else begin
      bit ra, rs, rd, acc;
      ra = kb[2] && !m_pa;
      rs = kb[1] && !m_ps;
      rd = kb[0] && !m_pd;
      m_go = 0; m_sp = 0; acc = 0;
      case (m_phase)
        0: if (ra) begin m_phase = 1; m_elapsed = 0; m_gear = 1; m_fs = 0; end
        1: begin
          if (kb[3]) begin m_fs = 1; m_phase = 3; end
          else begin
            m_elapsed++;
            if (m_elapsed == STEPS * TICK) begin m_phase = 2; m_go = 1; end
          end
        end
        2: begin
          if (m_lock == 0 && rd && !rs && m_gear < MAXG) begin m_gear++; acc = 1; end
          else if (m_lock == 0 && rs && !rd && m_gear > 1) begin m_gear--; acc = 1; end
          m_sp = acc;
          if (fl) m_phase = 3;
        end
        default: if (ra) begin m_phase = 0; m_fs = 0; m_gear = 1; end
      endcase
`ifdef RACE_CTRL_SHIFT_LOCKOUT_EN
      if (acc) m_lock = LOCK - 1;
      else if (m_lock > 0) m_lock--;
`endif
      if (m_phase != 2) m_lock = 0;
      m_thr = (m_phase == 2) && kb[3];
      m_pa = kb[2]; m_ps = kb[1]; m_pd = kb[0];
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("m_state", int'(state), m_phase);
      chk("m_countdown", int'(countdown), (m_phase == 1) ? STEPS - m_elapsed / TICK : 0);
      chk("m_go", int'(go), int'(m_go));
      chk("m_throttle", int'(throttle), int'(m_thr));
      chk("m_gear", int'(gear), m_gear);
      chk("m_shift_pulse", int'(shift_pulse), int'(m_sp));
      chk("m_false_start", int'(false_start), int'(m_fs));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press a key for one cycle, check gear/pulse the cycle after, then idle
  // long enough that any shift lockout has expired.
  task automatic press(input logic [3:0] key, input int exp_gear, input int exp_sp);
    kb = kb | key;
    step(1);
    $display("press key=%b gear=%0d shift_pulse=%0d", key, gear, shift_pulse);
    chk("press_gear", int'(gear), exp_gear);
    chk("press_pulse", int'(shift_pulse), exp_sp);
    kb = kb & ~key;
    step(LOCK + 2);
  endtask

  // Pulse A and run the countdown through to RACE.
  task automatic start_race();
    kb[2] = 1'b1; step(1); kb[2] = 1'b0;
    chk("start_state", int'(state), 1);
    step(STEPS * TICK);
    chk("start_go", int'(go), 1);
    chk("start_race", int'(state), 2);
    step(1);
  endtask

  initial begin
    #1 reset = 1'b1;
    started = 1;
    step(2);
    chk("rst_state", int'(state), 0);
    chk("rst_gear", int'(gear), 1);
    chk("rst_fs", int'(false_start), 0);
    reset = 1'b0;
    step(1);

    // 1. start sequence
    kb[2] = 1'b1; step(1); kb[2] = 1'b0;
    $display("start: state=%0d countdown=%0d", state, countdown);
    chk("t1_state", int'(state), 1);
    chk("t1_cd3", int'(countdown), 3);
    step(4);  chk("t1_cd2", int'(countdown), 2);
    step(4);  chk("t1_cd1", int'(countdown), 1);
    step(3);  chk("t1_nogo", int'(go), 0); chk("t1_still_cd", int'(state), 1);
    step(1);  chk("t1_go", int'(go), 1);   chk("t1_race", int'(state), 2);
    chk("t1_cd0", int'(countdown), 0);
    step(1);  chk("t1_go_low", int'(go), 0);

    // 3. gear limits
    press(4'b0001, 2, 1); press(4'b0001, 3, 1); press(4'b0001, 4, 1);
    press(4'b0001, 5, 1); press(4'b0001, 5, 0); press(4'b0001, 5, 0);
    press(4'b0010, 4, 1); press(4'b0010, 3, 1); press(4'b0010, 2, 1);
    press(4'b0010, 1, 1); press(4'b0010, 1, 0);

    // 4. same-cycle and held shifts
    press(4'b0001, 2, 1); press(4'b0001, 3, 1);
    press(4'b0011, 3, 0);
    kb[0] = 1'b1; step(1);
    chk("t4_held_first", int'(gear), 4);
    step(19);
    chk("t4_held_gear", int'(gear), 4);
    chk("t4_held_pulse", int'(shift_pulse), 0);
    kb[0] = 1'b0; step(2);

    // 5. throttle and finish
    kb[3] = 1'b1; step(1);
    chk("t5_thr", int'(throttle), 1);
    fl = 1'b1; step(1);
    $display("finish: state=%0d throttle=%0d gear=%0d", state, throttle, gear);
    chk("t5_state", int'(state), 3);
    chk("t5_thr0", int'(throttle), 0);
    chk("t5_gear", int'(gear), 4);
    kb[3] = 1'b0; fl = 1'b0; step(2);
    kb[2] = 1'b1; step(1); kb[2] = 1'b0;
    chk("t5_idle", int'(state), 0);
    chk("t5_gear1", int'(gear), 1);
    step(1);

    // 2. false start
    kb[2] = 1'b1; step(1); kb[2] = 1'b0;
    step(4);
    chk("t2_cd2", int'(countdown), 2);
    kb[3] = 1'b1; step(1); kb[3] = 1'b0;
    $display("false start: state=%0d fs=%0d", state, false_start);
    chk("t2_fs", int'(false_start), 1);
    chk("t2_state", int'(state), 3);
    chk("t2_cd0", int'(countdown), 0);
    step(2);
    chk("t2_fs_held", int'(false_start), 1);
    kb[2] = 1'b1; step(1); kb[2] = 1'b0;
    chk("t2_idle", int'(state), 0);
    chk("t2_fs_clr", int'(false_start), 0);
    step(1);

    // race again up to gear 4 (lockout behaviour when enabled)
    start_race();
`ifdef RACE_CTRL_SHIFT_LOCKOUT_EN
    kb[0] = 1'b1; step(1); kb[0] = 1'b0;
    chk("lk_first", int'(gear), 2);
    step(2);
    kb[0] = 1'b1; step(1); kb[0] = 1'b0;
    chk("lk_blocked_gear", int'(gear), 2);
    chk("lk_blocked_pulse", int'(shift_pulse), 0);
    step(5);
    kb[0] = 1'b1; step(1); kb[0] = 1'b0;
    chk("lk_accept_gear", int'(gear), 3);
    chk("lk_accept_pulse", int'(shift_pulse), 1);
    step(LOCK + 2);
`else
    press(4'b0001, 2, 1); press(4'b0001, 3, 1);
`endif
    press(4'b0001, 4, 1);

    // 6. async reset mid-race
    kb[3] = 1'b1; step(1);
    chk("t6_pre_gear", int'(gear), 4);
    #2 reset = 1'b1;
    #1;
    $display("async reset: state=%0d gear=%0d throttle=%0d", state, gear, throttle);
    chk("t6_state", int'(state), 0);
    chk("t6_cd", int'(countdown), 0);
    chk("t6_go", int'(go), 0);
    chk("t6_thr", int'(throttle), 0);
    chk("t6_gear", int'(gear), 1);
    chk("t6_sp", int'(shift_pulse), 0);
    chk("t6_fs", int'(false_start), 0);
    kb[3] = 1'b0;
    step(2);
    reset = 1'b0;
    step(3);
    chk("t6_after", int'(state), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/race_ctrl.md
Name: race_ctrl

Overview:
- Game sequencing controller for the drag race.
- Consumes the registered key-state vector from the keyboard game-code decoder and sequences the race: idle, start countdown, race, finish.
- Owns gear selection, throttle gating and false-start detection; outputs feed the car physics and display logic.
- Key mapping: bit3 = W (throttle), bit2 = A (start/restart), bit1 = S (shift down), bit0 = D (shift up).

Parameters:
- WIDTH, 4, width of kb_key_pressed; must be 4.
- TICK_CYCLES, 32_500_000, clk cycles per countdown step (0.5 s at 65 MHz).
- COUNT_STEPS, 3, number of countdown lights, 1..3.
- MAX_GEAR, 5, highest gear, 2..7.
- LOCKOUT_CYCLES, 6_500_000, shift lockout length; used only with SHIFT_LOCKOUT_EN.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- kb_key_pressed  input  WIDTH  key levels {W,A,S,D}, synchronous to clk.
- finish_line  input  1  level from game logic; car crossed the finish line.
- state  output  2  0=IDLE, 1=COUNTDOWN, 2=RACE, 3=FINISH.
- countdown  output  2  lights remaining; 0 outside COUNTDOWN.
- go  output  1  one-cycle pulse on COUNTDOWN->RACE.
- throttle  output  1  W level gated by RACE.
- gear  output  3  current gear, 1..MAX_GEAR.
- shift_pulse  output  1  one-cycle pulse on any accepted gear change.
- false_start  output  1  sticky flag; W held during COUNTDOWN.

Behaviour:
- Reset (async, any time, including mid-race):
  - state=IDLE, countdown=0, go=0, throttle=0, gear=1, shift_pulse=0, false_start=0.
  - Tick counter = 0; key-history register = 0.
- Edge detection:
  - prev register holds the previous cycle's A, S and D.
  - rise_X = X & ~prev_X.
  - All outputs are registered and update on the clk edge after the sampled input; latency is 1 cycle.
- IDLE:
  - throttle=0.
  - rise_A -> COUNTDOWN; load countdown=COUNT_STEPS, tick=0, gear=1, false_start=0.
- COUNTDOWN:
  - tick increments each cycle; at TICK_CYCLES-1 it wraps to 0.
  - On wrap with countdown>1: countdown decrements.
  - On wrap with countdown==1: countdown=0, go=1 for one cycle, state -> RACE.
  - COUNTDOWN therefore lasts exactly COUNT_STEPS*TICK_CYCLES cycles.
  - W=1 in any COUNTDOWN cycle: false_start=1, countdown=0, state -> FINISH. This takes priority over a same-cycle wrap.
  - Shift keys are ignored.
- RACE:
  - throttle = W, registered.
  - rise_D with gear<MAX_GEAR: gear+1, shift_pulse=1.
  - rise_S with gear>1: gear-1, shift_pulse=1.
  - rise_D and rise_S in the same cycle: no change, no pulse.
  - Shift at a limit (MAX_GEAR up, 1 down): ignored, no pulse.
  - Holding a shift key produces exactly one shift.
  - finish_line=1 -> FINISH; a shift in the same cycle is still applied.
- FINISH:
  - throttle=0; gear held; false_start held.
  - rise_A -> IDLE; false_start cleared; gear=1.
- rise_A in COUNTDOWN or RACE: ignored, no abort.
- Counters:
  - Tick counter width = clog2(TICK_CYCLES).
  - Gear arithmetic is 3-bit and saturating per the rules above; it never wraps.

Optional Feature:
- Macro: RACE_CTRL_SHIFT_LOCKOUT_EN.
- When defined:
  - Each accepted shift loads a lockout counter with LOCKOUT_CYCLES-1.
  - While the counter is nonzero, rise_S and rise_D are ignored, with no pulse.
  - The counter decrements each cycle and is cleared on leaving RACE and on reset.
- When undefined: no lockout counter is synthesized; every qualifying edge shifts.

Test Plan:
All tests use TICK_CYCLES=4, COUNT_STEPS=3, MAX_GEAR=5 and LOCKOUT_CYCLES=8.
1. Start sequence: reset released, A pulsed 1 cycle -> state=1 and countdown=3 next cycle; countdown=2 after 4 cycles, 1 after 8; go pulses and state=2 exactly 12 cycles after entry.
2. False start: during COUNTDOWN with countdown=2, W=1 for one cycle -> next cycle false_start=1, state=3, countdown=0; A rise -> state=0, false_start=0.
3. Gear limits: in RACE, 6 separate D presses -> gear 2,3,4,5,5,5 with shift_pulse only on the first 4; then 5 S presses -> 4,3,2,1,1.
4. Same-cycle and held shifts: S and D rise in the same cycle at gear 3 -> gear stays 3, no pulse; D held 20 cycles -> exactly one shift.
5. Throttle and finish: W=1 in RACE -> throttle=1 one cycle later; finish_line=1 -> state=3, throttle=0 next cycle, gear held.
6. Async reset mid-RACE at gear 4 -> all outputs return to reset values immediately, without waiting for a clk edge. With RACE_CTRL_SHIFT_LOCKOUT_EN defined: a second D press 3 cycles after a shift is ignored, and a D press 9 cycles after the shift is accepted.
